// File: rtl/bus_sram_bridge_pkg.sv
// Shared bus definitions: command encoding and address-offset helper used by
// bus slaves that map a byte-addressed bus onto word-addressed memories.
package bus_sram_bridge_pkg;

  typedef enum logic {
    BUS_READ  = 1'b0,
    BUS_WRITE = 1'b1
  } bus_cmd_t;

  // Number of byte-address bits below a DW-bit word.
  function automatic int unsigned byte_off(input int unsigned dw);
    return $clog2(dw / 8);
  endfunction

endpackage

// File: rtl/bus_sram_bridge_if.sv
// Bus transaction interface (valid/ready request and response channels) and
// synchronous single-port SRAM interface with one-cycle read latency.
interface bus_trans_if_t
  import bus_sram_bridge_pkg::*;
#(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  typedef struct packed {
    bus_cmd_t            cmd;
    logic [AW-1:0]       addr;
    logic [DW-1:0]       data;
    logic [DW/8-1:0]     strb;
  } req_pkt_t;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          ok;
  } rsp_pkt_t;

  logic     req_vld;
  logic     req_rdy;
  req_pkt_t req_pkt;
  logic     rsp_vld;
  logic     rsp_rdy;
  rsp_pkt_t rsp_pkt;

  modport slave  (input  req_vld, req_pkt, rsp_rdy, output req_rdy, rsp_vld, rsp_pkt);
  modport master (output req_vld, req_pkt, rsp_rdy, input  req_rdy, rsp_vld, rsp_pkt);
endinterface

interface sram_if_t #(
  parameter int unsigned AW = 15,
  parameter int unsigned DW = 32
);
  logic [AW-1:0] addr;
  logic          wen;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;

  modport master (output addr, wen, wdata, input  rdata);
  modport slave  (input  addr, wen, wdata, output rdata);
endinterface

// File: rtl/bus_strobe_merge.sv
// Byte-lane merge: each byte comes from new_data when its strobe bit is set,
// otherwise from old_data. Shared by bus slaves doing read-modify-write.
module bus_strobe_merge #(
  parameter int unsigned DW = 32
) (
  input  logic [DW-1:0]   old_data,
  input  logic [DW-1:0]   new_data,
  input  logic [DW/8-1:0] strobe,
  output logic [DW-1:0]   merged
);

  always_comb begin
    merged = old_data;
    for (int unsigned i = 0; i < DW / 8; i++) begin
      if (strobe[i]) merged[i*8 +: 8] = new_data[i*8 +: 8];
    end
  end

endmodule

// File: rtl/bus_sram_bridge.sv
// Bridges the bus transaction protocol onto a synchronous single-port SRAM,
// one transaction at a time, with read-modify-write for partial strobes.
module bus_sram_bridge
  import bus_sram_bridge_pkg::*;
#(
  parameter int unsigned   AW        = 32,
  parameter int unsigned   DW        = 32,
  parameter int unsigned   SRAM_AW   = 15,
  parameter logic [AW-1:0] BASE_ADDR = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  bus_trans_if_t.slave  bus,
  sram_if_t.master      sram
);

  localparam int unsigned OFF = byte_off(DW);
  localparam int unsigned NB  = DW / 8;

  typedef enum logic [1:0] {IDLE, RD, RMW, RSP} state_t;

  state_t               state;
  bus_cmd_t             cmd_q;
  logic [SRAM_AW-1:0]   waddr_q;
  logic [DW-1:0]        data_q;
  logic [NB-1:0]        strb_q;
  logic                 in_range_q;

  logic [SRAM_AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]        wdata_q, wdata_d;
  logic                 wen_d;
  logic [DW-1:0]        merged;

  logic                 rsp_vld_q;
  logic [DW-1:0]        rsp_data_q;
  logic                 rsp_ok_q;

  logic                 req_fire;
  logic                 req_wr;
  logic                 req_in_range;
  logic                 req_full;
  logic                 req_none;
  logic [AW-1:0]        req_off;
  logic [SRAM_AW-1:0]   req_waddr;

  assign req_fire     = (state == IDLE) && bus.req_vld;
  assign req_wr       = (bus.req_pkt.cmd == BUS_WRITE);
  assign req_off      = bus.req_pkt.addr - BASE_ADDR;
  assign req_in_range = ((req_off >> (SRAM_AW + OFF)) == '0);
  assign req_waddr    = SRAM_AW'(req_off >> OFF);
  assign req_full     = &bus.req_pkt.strb;
  assign req_none     = ~|bus.req_pkt.strb;

  assign bus.req_rdy  = (state == IDLE);
  assign bus.rsp_vld  = rsp_vld_q;
  assign bus.rsp_pkt  = {rsp_data_q, rsp_ok_q};

  assign sram.addr    = addr_d;
  assign sram.wdata   = wdata_d;
  assign sram.wen     = wen_d;

  bus_strobe_merge #(.DW(DW)) u_merge (
    .old_data (sram.rdata),
    .new_data (data_q),
    .strobe   (strb_q),
    .merged   (merged)
  );

  // SRAM address/data follow the request in the accept cycle, the latched
  // request during the RMW write, and otherwise hold their last driven value.
  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wen_d   = 1'b0;
    if (req_fire && req_in_range) begin
      if (!req_wr || !req_none) addr_d = req_waddr;
      if (req_wr && req_full) begin
        wdata_d = bus.req_pkt.data;
        wen_d   = 1'b1;
      end
    end else if (state == RMW) begin
      addr_d  = waddr_q;
      wdata_d = merged;
      wen_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cmd_q      <= BUS_READ;
      waddr_q    <= '0;
      data_q     <= '0;
      strb_q     <= '0;
      in_range_q <= 1'b0;
      rsp_vld_q  <= 1'b0;
      rsp_data_q <= '0;
      rsp_ok_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_vld) begin
            cmd_q      <= bus.req_pkt.cmd;
            waddr_q    <= req_waddr;
            data_q     <= bus.req_pkt.data;
            strb_q     <= bus.req_pkt.strb;
            in_range_q <= req_in_range;
            if (req_in_range && !req_wr) begin
              state <= RD;
            end else if (req_in_range && !req_full && !req_none) begin
              state <= RMW;
            end else begin
              rsp_vld_q  <= 1'b1;
              rsp_data_q <= '0;
              rsp_ok_q   <= req_in_range;
              state      <= RSP;
            end
          end
        end
        RD: begin
          rsp_vld_q  <= 1'b1;
          rsp_data_q <= (cmd_q == BUS_READ) ? sram.rdata : '0;
          rsp_ok_q   <= in_range_q;
          state      <= RSP;
        end
        RMW: begin
          rsp_vld_q  <= 1'b1;
          rsp_data_q <= '0;
          rsp_ok_q   <= in_range_q;
          state      <= RSP;
        end
        RSP: begin
          if (bus.rsp_rdy) begin
            rsp_vld_q <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/bus_sram_bridge.md
BUS_SRAM_BRIDGE -- requirements
Module: bus_sram_bridge

Interface
REQ-001 SHALL have parameter AW, default 32, bus address width.
REQ-002 SHALL have parameter DW, default 32, bus and SRAM data width; DW is a multiple of 8.
REQ-003 SHALL have parameter SRAM_AW, default 15, SRAM word-address width.
REQ-004 SHALL have parameter BASE_ADDR, default 0, bus byte address of SRAM word 0; aligned to the SRAM window size.
REQ-005 SHALL have port clk, input, 1, the single clock; all state on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port bus, bus_trans_if_t.slave, AW/DW, the responder end of the bus transaction protocol.
REQ-008 SHALL have port sram, sram_if_t.master, SRAM_AW/DW, synchronous single-port SRAM with one-cycle read latency.

Function
REQ-009 SHALL define OFF = log2(DW/8); SRAM word address = (addr - BASE_ADDR) >> OFF, truncated to SRAM_AW bits; addr[OFF-1:0] ignored.
REQ-010 SHALL treat a request as in-range iff (addr - BASE_ADDR), unsigned AW-bit, is below 2^(SRAM_AW+OFF).
REQ-011 SHALL implement FSM states IDLE, RD, RMW, RSP; req_rdy = 1 only in IDLE; one transaction outstanding.
REQ-012 SHALL, on request handshake in cycle T, drive sram.addr/wen/wdata combinationally from req_pkt in T.
REQ-013 Read, in-range: sram read (wen=0) in T; IDLE->RD; RD latches sram.rdata; RD->RSP; rsp_vld first high at T+2, data=rdata, ok=1.
REQ-014 Write, strobe all ones, in-range: wen=1, wdata=req data in T; IDLE->RSP; rsp_vld at T+1, data=0, ok=1.
REQ-015 Write, partial nonzero strobe, in-range: sram read in T; IDLE->RMW; in T+1 wen=1, wdata byte i = strobe[i] ? req byte i : rdata byte i; RMW->RSP; rsp_vld at T+2, ok=1.
REQ-016 Write with strobe all zero: no SRAM write; rsp at T+1, ok=1.
REQ-017 Out-of-range request, read or write: no SRAM access (wen=0); rsp at T+1, data=0, ok=0.
REQ-018 Read ignores strobe.
REQ-019 SHALL hold rsp_vld and rsp_pkt stable from assertion until rsp_vld&rsp_rdy; RSP->IDLE on that handshake; next request accepted no earlier than the following cycle.
REQ-020 With rsp_rdy held low, SHALL stall in RSP indefinitely with sram.wen=0.
REQ-021 SHALL drive sram.wen=1 only in the write cycle of REQ-014/REQ-015; sram.addr and sram.wdata hold their last registered values when no access is in progress.
REQ-022 SHALL latch the request fields (cmd, word address, data, strobe, range flag) at handshake for use in RD/RMW/RSP.

Reset
REQ-023 On rst_n low: state=IDLE (req_rdy=1), rsp_vld=0, rsp_pkt=0, sram.wen=0, sram.addr=0, sram.wdata=0, latched request cleared.
REQ-024 Reset mid-transaction SHALL drop the transaction with no response; a pending RMW write is not issued.

Structure
REQ-025 bus_cmd_t SHALL stay in the shared bus header; the FSM state enum is local to this module.
REQ-026 Byte-merge logic SHALL be a sub-module bus_strobe_merge (inputs old, new, strobe; output merged), reusable by other bus slaves.
REQ-027 SHALL contain no other sub-modules; the SRAM model belongs to the bench only.

Verification
REQ-028 Write 0x0000_0010 data 0xDEAD_BEEF strobe 0xF, then read 0x10 -> write rsp at T+1 ok=1; read rsp at T+2 data 0xDEAD_BEEF ok=1.
REQ-029 SRAM word 4 holds 0x1122_3344; write 0x10 data 0xAABB_CCDD strobe 0x5 -> wen=1 at T+1 wdata 0x11BB_33DD; later read returns 0x11BB_33DD.
REQ-030 Read 0x0002_0000 (SRAM_AW=15, BASE_ADDR=0) -> wen=0 throughout; rsp at T+1 ok=0 data 0.
REQ-031 Read with rsp_rdy low for 5 cycles -> rsp_vld and data stable 5 cycles; req_rdy=0; accept resumes the cycle after the rsp handshake.
REQ-032 Write strobe 0x0 to 0x20 -> no wen pulse, rsp ok=1, word 8 unchanged.
REQ-033 Assert rst_n low during the RMW cycle of a partial write -> no wen, rsp_vld=0, req_rdy=1 after release, word unchanged.
